// File: rtl/wb_sram_responder.sv
// Wishbone classic (B3) slave backed by a word-organised 16-bit on-chip memory.
// Programmable read/write wait states; one ack or err pulse per accepted strobe.
module wb_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned READ_WAIT  = 0,
  parameter int unsigned WRITE_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned TAG_LSB = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned SEL_W   = 2;

  localparam logic [CNT_W-1:0] RD_WAIT = CNT_W'(READ_WAIT);
  localparam logic [CNT_W-1:0] WR_WAIT = CNT_W'(WRITE_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdat_q, wdat_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       rdat_q, rdat_d;

  logic                    req_c;
  logic                    hit_c;
  logic [ADDR_WIDTH-1:0]   adr_idx_c;
  logic [CNT_W-1:0]        wait_c;
  logic [ADDR_WIDTH-1:0]   acc_idx_c;
  logic [DATA_W-1:0]       acc_dat_c;
  logic [SEL_W-1:0]        acc_sel_c;
  logic [DATA_W-1:0]       mem_rd_c;
  logic                    mem_we_c;
  logic                    unused_c;

  logic [DATA_W-1:0]       mem_q [DEPTH];

  assign req_c     = wb_cyc_i & wb_stb_i;
  assign hit_c     = (wb_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign adr_idx_c = wb_adr_i[ADDR_WIDTH:1];
  assign wait_c    = wb_we_i ? WR_WAIT : RD_WAIT;
  assign unused_c  = wb_adr_i[0];

  // Zero-wait transfers use the live bus; waited ones use the values captured at acceptance.
  assign acc_idx_c = (state_q == ST_IDLE) ? adr_idx_c : idx_q;
  assign acc_dat_c = (state_q == ST_IDLE) ? wb_dat_i  : wdat_q;
  assign acc_sel_c = (state_q == ST_IDLE) ? wb_sel_i  : sel_q;
  assign mem_rd_c  = mem_q[acc_idx_c];

  // Next-state, capture and termination logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    sel_d    = sel_q;
    we_d     = we_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    rdat_d   = '0;
    mem_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          idx_d  = adr_idx_c;
          wdat_d = wb_dat_i;
          sel_d  = wb_sel_i;
          we_d   = wb_we_i;
          if (!hit_c) begin
            state_d = ST_TERM;
            err_d   = 1'b1;
          end else if (wait_c == '0) begin
            state_d = ST_TERM;
            ack_d   = 1'b1;
            if (wb_we_i) begin
              mem_we_c = 1'b1;
            end else begin
              rdat_d = mem_rd_c;
            end
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_c;
          end
        end
      end

      ST_WAIT: begin
        if (!req_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_TERM;
          cnt_d   = '0;
          ack_d   = 1'b1;
          if (we_q) begin
            mem_we_c = 1'b1;
          end else begin
            rdat_d = mem_rd_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_TERM: begin
        state_d = ST_DEAD;
      end

      ST_DEAD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // Storage is not reset; a write presented while reset is held must not land.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && mem_we_c) begin
      if (acc_sel_c[0]) begin
        mem_q[acc_idx_c][7:0] <= acc_dat_c[7:0];
      end
      if (acc_sel_c[1]) begin
        mem_q[acc_idx_c][15:8] <= acc_dat_c[15:8];
      end
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
